// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR flip-flop bank driver: FSM states,
// per-channel command encodings and the per-channel command decision.
package sr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    VERIFY,
    DONE,
    ERR
  } state_t;

  typedef logic [1:0] sr_cmd_t;

  // Encoded as {s, r} for one channel.
  localparam sr_cmd_t SR_HOLD    = 2'b00;
  localparam sr_cmd_t SR_SET     = 2'b10;
  localparam sr_cmd_t SR_RST     = 2'b01;
  localparam sr_cmd_t SR_ILLEGAL = 2'b11;

  // Decide what a channel needs to reach its target from its current q.
  // The forbidden encoding is folded to HOLD so it can never reach a flop.
  function automatic sr_cmd_t sr_cmd(input logic target, input logic mask,
                                     input logic q);
    sr_cmd_t c;
    c = {mask & target & ~q, mask & ~target & q};
    return (c == SR_ILLEGAL) ? SR_HOLD : c;
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter with a zero flag; times both the pulse length and
// the verify timeout of the SR driver.
module sr_drv_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_ctrl_driver.sv
// Command-side driver for a bank of SR flops: accepts a masked target,
// pulses s/r for a fixed time, then verifies q against the target.
module sr_ctrl_driver
  import sr_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int TIMEOUT      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] req_mask,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] err_bits
);

  localparam int MAX_CYC = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT - 1);

  state_t           state;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] rst_vec;
  logic             accept;
  logic             match;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [CW-1:0]    tmr_load_val;
  sr_cmd_t          cmd;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    set_vec = '0;
    rst_vec = '0;
    cmd     = SR_HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      cmd        = sr_cmd(req_target[i], req_mask[i], q_fb[i]);
      set_vec[i] = (cmd == SR_SET);
      rst_vec[i] = (cmd == SR_RST);
    end
  end

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign match     = ((q_fb & mask_q) == (target_q & mask_q));

  // The timer is reloaded on entry to PULSE and again on entry to VERIFY.
  assign tmr_load     = accept || ((state == PULSE) && tmr_zero);
  assign tmr_load_val = (state == IDLE) ? PULSE_LOAD : TIMEOUT_LOAD;
  assign tmr_dec      = (state == PULSE) || (state == VERIFY);

  sr_drv_timer #(
    .WIDTH(CW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s        <= '0;
      r        <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_bits <= '0;
      target_q <= '0;
      mask_q   <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            target_q <= req_target;
            mask_q   <= req_mask;
            err_bits <= '0;
            if ((set_vec | rst_vec) == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PULSE;
              s     <= set_vec;
              r     <= rst_vec;
            end
          end
        end
        PULSE: begin
          if (tmr_zero) begin
            s     <= '0;
            r     <= '0;
            state <= VERIFY;
          end
        end
        VERIFY: begin
          // A match on the last allowed cycle still completes cleanly.
          if (match) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (tmr_zero) begin
            state    <= ERR;
            error    <= 1'b1;
            err_bits <= (q_fb ^ target_q) & mask_q;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_ctrl_driver.sv
// Self-checking bench for sr_ctrl_driver driving a modelled SR flop bank.
module tb_sr_ctrl_driver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_target;
  logic [W-1:0] req_mask;
  logic [W-1:0] q_fb;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] err_bits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_ctrl_driver #(
    .WIDTH       (W),
    .PULSE_CYCLES(2),
    .TIMEOUT     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_target(req_target),
    .req_mask  (req_mask),
    .q_fb      (q_fb),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_bits  (err_bits)
  );

  // SR flop bank model; stuck bits never change, preset loads a start value.
  logic [W-1:0] model_q = '0;
  logic [W-1:0] stuck = '0;
  logic         preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;

  always @(posedge clk) begin
    if (preset_en) begin
      model_q <= preset_val;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!stuck[i]) begin
          if (s[i]) model_q[i] <= 1'b1;
          else if (r[i]) model_q[i] <= 1'b0;
        end
      end
    end
  end
  assign q_fb = model_q;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected completions.
  typedef struct {
    string        name;
    logic         exp_err;
    logic [W-1:0] exp_err_bits;
  } sb_t;
  sb_t sb[$];

  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("s_and_r_zero", {28'd0, s & r}, 32'd0);
      check("done_error_exclusive", {31'd0, done & error}, 32'd0);
      if (done || error) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", {31'd0, done | error}, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check({e.name, "_error_flag"}, {31'd0, error}, {31'd0, e.exp_err});
          check({e.name, "_done_flag"}, {31'd0, done}, {31'd0, ~e.exp_err});
          if (e.exp_err)
            check({e.name, "_err_bits"}, {28'd0, err_bits}, {28'd0, e.exp_err_bits});
        end
      end
    end
  end

  typedef struct {
    string        name;
    logic [W-1:0] q0;
    logic [W-1:0] target;
    logic [W-1:0] mask;
    logic [W-1:0] stuck;
    logic [W-1:0] exp_s;
    logic [W-1:0] exp_r;
    int           exp_pulses;
    int           exp_verify;
    logic         exp_err;
    logic [W-1:0] exp_err_bits;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int pulses;
    int verify;
    int n;
    logic fin;
    wait_ready(v.name);
    preset_en  = 1'b1;
    preset_val = v.q0;
    stuck      = v.stuck;
    @(posedge clk); #1;
    preset_en  = 1'b0;
    req_valid  = 1'b1;
    req_target = v.target;
    req_mask   = v.mask;
    sb.push_back('{v.name, v.exp_err, v.exp_err_bits});
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({v.name, "_err_bits_cleared"}, {28'd0, err_bits}, 32'd0);
    pulses = 0;
    verify = 0;
    fin    = 1'b0;
    n      = 0;
    while (!fin && n < 40) begin
      if (done || error) begin
        fin = 1'b1;
      end else begin
        if ((s | r) != '0) begin
          pulses++;
          check({v.name, "_s"}, {28'd0, s}, {28'd0, v.exp_s});
          check({v.name, "_r"}, {28'd0, r}, {28'd0, v.exp_r});
        end else if (busy) begin
          verify++;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    check({v.name, "_completed"}, {31'd0, fin}, 32'd1);
    check({v.name, "_pulse_cycles"}, pulses, v.exp_pulses);
    check({v.name, "_verify_cycles"}, verify, v.exp_verify);
    check({v.name, "_final_q"}, {28'd0, model_q}, {28'd0, v.exp_q});
    @(posedge clk); #1;
    check({v.name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    check({v.name, "_single_pulse"}, {30'd0, done, error}, 32'd0);
    check({v.name, "_err_bits_held"}, {28'd0, err_bits}, {28'd0, v.exp_err_bits});
  endtask

  initial begin
    vecs[0] = '{"full",    4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b1010, 4'b0101, 2, 1, 1'b0, 4'b0000, 4'b1010};
    vecs[1] = '{"masked",  4'b0000, 4'b1111, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 2, 1, 1'b0, 4'b0000, 4'b0011};
    vecs[2] = '{"timeout", 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 2, 8, 1'b1, 4'b0010, 4'b0000};
    vecs[3] = '{"noop",    4'b1100, 4'b1100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1'b0, 4'b0000, 4'b1100};
    vecs[4] = '{"unmasked_ignored", 4'b1001, 4'b0110, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 2, 1, 1'b0, 4'b0000, 4'b1111};
    vecs[5] = '{"reset_only", 4'b1111, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 2, 1, 1'b0, 4'b0000, 4'b0101};

    // Reset held with a live request that must be ignored.
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_target = 4'b1111;
    req_mask   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mon_en = 1'b1;
      check("rst_outputs", {s, r, 4'd0, done, error, busy, 1'b0}, 16'd0);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_ready_after_release", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check("rst_idle_after_release", {30'd0, busy, req_ready}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset on the first pulse cycle discards the in-flight request.
    wait_ready("midrst");
    preset_en  = 1'b1;
    preset_val = 4'b0000;
    stuck      = 4'b0000;
    @(posedge clk); #1;
    preset_en  = 1'b0;
    req_valid  = 1'b1;
    req_target = 4'b1111;
    req_mask   = 4'b1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midrst_first_pulse_s", {28'd0, s}, 32'hF);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_cleared", {s, r, err_bits, 1'b0, done, error, busy}, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_quiet", {30'd0, done, error}, 32'd0);
    end
    run_vec(vecs[0]);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_ctrl_driver.md
Name: sr_ctrl_driver

Overview:
- Command-side driver for a bank of WIDTH synchronous SR flip-flops. It is the producer of the s/r inputs those flops consume.
- Accepts a masked target-state request over a valid/ready handshake and compares it against q feedback.
- Issues non-overlapping set/reset pulses of fixed length, then verifies the flops reached the target within a timeout.
- Guarantees the forbidden s=r=1 combination is never driven.

Parameters:
- WIDTH, 4, number of SR channels driven.
- PULSE_CYCLES, 2, cycles each s/r pulse is held; must be >=1.
- TIMEOUT, 8, max VERIFY cycles before error; must be >=1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_target  input  WIDTH  desired q value per channel.
- req_mask  input  WIDTH  1 = channel participates; 0 = untouched.
- q_fb  input  WIDTH  q outputs of the driven flops.
- s  output  WIDTH  set commands to the flops.
- r  output  WIDTH  reset commands to the flops.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse: request completed, all masked bits match.
- error  output  1  one-cycle pulse: verify timed out.
- err_bits  output  WIDTH  mismatching masked bits at timeout; held until the next accepted request.

Behaviour:
- Reset values (one clock, synchronous, active-high): state=IDLE; s=0, r=0, done=0, error=0, err_bits=0, busy=0.
  - req_valid is ignored while reset is high.
  - req_ready=1 from the first cycle after reset deasserts.
- All outputs except req_ready and busy are registered.
- FSM states: IDLE, PULSE, VERIFY, DONE, ERR.
- IDLE, handshake at edge T when req_valid && req_ready:
  - Latch target, mask; clear err_bits.
  - set_vec = mask & target & ~q_fb.
  - rst_vec = mask & ~target & q_fb, using q_fb sampled at T.
  - If set_vec|rst_vec == 0: go to DONE, done=1 during T+1.
  - Otherwise go to PULSE.
- PULSE:
  - s=set_vec and r=rst_vec during cycles T+1..T+PULSE_CYCLES.
  - Then s=r=0 and go to VERIFY.
- VERIFY:
  - Counter starts at 0 and increments each cycle.
  - If (q_fb & mask) == (target & mask): go to DONE.
  - If the counter reaches TIMEOUT-1 without a match: go to ERR, err_bits = (q_fb ^ target) & mask.
  - A match on the final cycle wins over timeout.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: error=1 for exactly one cycle, then IDLE.
- Ordering: done and error are never both high.
- req_ready is low in PULSE/VERIFY/DONE/ERR, so back-to-back requests cost at least 2 cycles each (no-op case).
- Invariant: (s & r) == 0 at all times, including across reset.
- Unmasked channels: s=r=0 always, and q_fb for them is ignored.
- Reset mid-operation:
  - s, r, done, error clear at the next edge; state=IDLE; the in-flight request is discarded.
  - No done or error pulse is emitted for it; err_bits=0.
- Counter width: $clog2(max(PULSE_CYCLES,TIMEOUT)+1). The counter is shared between PULSE and VERIFY and cleared on each state entry.

Decomposition:
- Package sr_pkg holds:
  - state enum (IDLE, PULSE, VERIFY, DONE, ERR);
  - per-channel command encoding constants SR_HOLD=2'b00, SR_SET=2'b10, SR_RST=2'b01, SR_ILLEGAL=2'b11;
  - a function computing set/reset vectors from target, mask, q.
- One sub-module: sr_drv_timer, a loadable down-counter with a zero flag used for both pulse length and timeout.
- Everything else lives in sr_ctrl_driver.

Test Plan (WIDTH=4, PULSE_CYCLES=2, TIMEOUT=8; bench models SR flops driven by s/r into q_fb):
- Reset: hold reset 3 cycles with req_valid=1, target=1111, mask=1111 -> s=r=0000, done=error=0, busy=0 throughout; req_ready=1 the cycle after release.
- Full update: q_fb=0101, target=1010, mask=1111 -> s=1010, r=0101 for exactly 2 cycles, then 0000; model q becomes 1010; done pulses once; s&r==0 every cycle.
- Masked update: q_fb=0000, target=1111, mask=0011 -> s=0011, r=0000; bits 3:2 never driven; done pulses; final q=0011.
- No-op: q_fb=1100, target=1100, mask=1111 -> s=r=0 always; done=1 on T+1; req_ready high again on T+2.
- Timeout: model ignores bit 1 (stuck 0), q_fb=0000, target=0010, mask=0010 -> s=0010 for 2 cycles; error pulse on the 8th VERIFY cycle; err_bits=0010; done never asserts.
- Reset mid-PULSE: assert reset on the 1st pulse cycle -> s=r=0 next edge, no done/error, err_bits=0; a fresh request afterward completes normally.
